// File: rtl/seg7_pkg.sv
// Shared seven-segment pattern constants and capture FSM state type,
// used by both the display encoder and the scan-capture receiver.
package seg7_pkg;

  localparam logic [6:0] SEG7_0     = 7'h7E;
  localparam logic [6:0] SEG7_1     = 7'h30;
  localparam logic [6:0] SEG7_2     = 7'h6D;
  localparam logic [6:0] SEG7_3     = 7'h79;
  localparam logic [6:0] SEG7_4     = 7'h33;
  localparam logic [6:0] SEG7_5     = 7'h5B;
  localparam logic [6:0] SEG7_6     = 7'h1F;
  localparam logic [6:0] SEG7_7     = 7'h70;
  localparam logic [6:0] SEG7_8     = 7'h7F;
  localparam logic [6:0] SEG7_9     = 7'h73;
  localparam logic [6:0] SEG7_BLANK = 7'h00;

  localparam logic [3:0] BCD_BLANK  = 4'hF;

  typedef enum logic {HUNT, CAPTURE} state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment to BCD decoder; blank decodes to F without
// error, any unrecognised pattern decodes to F with err set.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       err
);

  always_comb begin
    bcd = BCD_BLANK;
    err = 1'b0;
    case (seg)
      SEG7_0:     bcd = 4'd0;
      SEG7_1:     bcd = 4'd1;
      SEG7_2:     bcd = 4'd2;
      SEG7_3:     bcd = 4'd3;
      SEG7_4:     bcd = 4'd4;
      SEG7_5:     bcd = 4'd5;
      SEG7_6:     bcd = 4'd6;
      SEG7_7:     bcd = 4'd7;
      SEG7_8:     bcd = 4'd8;
      SEG7_9:     bcd = 4'd9;
      SEG7_BLANK: bcd = BCD_BLANK;
      default:    err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Captures a multiplexed seven-segment display into a BCD frame with a
// valid/ready output. Define SEG7_SCAN_CAPTURE_ACTIVE_LOW_EN for low-true pins.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     err_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun,
  output logic                  frame_err
);

  logic [6:0]        seg_i;
  logic [DIGITS-1:0] sel_i;

`ifdef SEG7_SCAN_CAPTURE_ACTIVE_LOW_EN
  assign seg_i = ~seg_in;
  assign sel_i = ~dig_sel;
`else
  assign seg_i = seg_in;
  assign sel_i = dig_sel;
`endif

  state_t                state_q, state_d;
  logic [2:0]            exp_q, exp_d;
  logic [3:0]            cnt_q, cnt_d, mh_q, mh_d;
  logic [6:0]            pseg_q;
  logic [DIGITS-1:0]     psel_q;
  logic [4*DIGITS-1:0]   asm_bcd_q, asm_bcd_d, bcd_q, bcd_d;
  logic [DIGITS-1:0]     asm_err_q, asm_err_d, err_q, err_d;
  logic                  valid_q, valid_d, ovr_q, ovr_d, ferr_q, ferr_d;

  logic       one_hot, multi, changed, sample, mh_fire;
  logic [2:0] idx;
  logic [3:0] dec_bcd;
  logic       dec_err;

  seg7_decode u_decode (.seg(seg_i), .bcd(dec_bcd), .err(dec_err));

  // cnt counts stable cycles minus one; the sample fires exactly once when it
  // reaches SETTLE-1 and the counter then parks at SETTLE until the bus moves.
  always_comb begin
    one_hot = $onehot(sel_i);
    multi   = (|sel_i) && !one_hot;
    changed = (sel_i != psel_q) || (seg_i != pseg_q);
    if (!one_hot || changed)     cnt_d = '0;
    else if (cnt_q != 4'(SETTLE)) cnt_d = cnt_q + 4'd1;
    else                          cnt_d = cnt_q;
    sample = one_hot && (cnt_d == 4'(SETTLE - 1));
    mh_fire = multi && (mh_q == 4'(SETTLE - 1));
    if (!multi)                  mh_d = '0;
    else if (mh_q != 4'(SETTLE)) mh_d = mh_q + 4'd1;
    else                         mh_d = mh_q;
    idx = '0;
    for (int k = 0; k < DIGITS; k++)
      if (sel_i[k]) idx = 3'(k);
  end

  always_comb begin
    logic start, store, abort, complete;
    start     = 1'b0;
    store     = 1'b0;
    abort     = 1'b0;
    complete  = 1'b0;
    state_d   = state_q;
    exp_d     = exp_q;
    asm_bcd_d = asm_bcd_q;
    asm_err_d = asm_err_q;
    case (state_q)
      HUNT:    start = sample && (idx == 3'd0);
      CAPTURE: begin
        if (mh_fire) abort = 1'b1;
        else if (sample) begin
          if (idx == exp_q) store = 1'b1;
          else begin
            abort = 1'b1;
            start = (idx == 3'd0);
          end
        end
      end
      default: state_d = HUNT;
    endcase
    if (abort) begin
      state_d   = HUNT;
      asm_bcd_d = '0;
      asm_err_d = '0;
    end
    if (start) begin
      asm_bcd_d      = '0;
      asm_err_d      = '0;
      asm_bcd_d[3:0] = dec_bcd;
      asm_err_d[0]   = dec_err;
      if (DIGITS == 1) complete = 1'b1;
      else begin
        exp_d   = 3'd1;
        state_d = CAPTURE;
      end
    end
    if (store) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (3'(k) == exp_q) begin
          asm_bcd_d[4*k +: 4] = dec_bcd;
          asm_err_d[k]        = dec_err;
        end
      end
      if (exp_q == 3'(DIGITS - 1)) begin
        complete = 1'b1;
        state_d  = HUNT;
      end else begin
        exp_d = exp_q + 3'd1;
      end
    end
    // A completed frame only replaces the output when the slot is free or
    // being consumed this cycle; otherwise the held frame wins.
    bcd_d   = bcd_q;
    err_d   = err_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    ferr_d  = abort;
    if (complete) begin
      if (!valid_q || out_ready) begin
        bcd_d   = asm_bcd_d;
        err_d   = asm_err_d;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      exp_q     <= '0;
      cnt_q     <= '0;
      mh_q      <= '0;
      pseg_q    <= '0;
      psel_q    <= '0;
      asm_bcd_q <= '0;
      asm_err_q <= '0;
      bcd_q     <= '0;
      err_q     <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      cnt_q     <= cnt_d;
      mh_q      <= mh_d;
      pseg_q    <= seg_i;
      psel_q    <= sel_i;
      asm_bcd_q <= asm_bcd_d;
      asm_err_q <= asm_err_d;
      bcd_q     <= bcd_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign bcd_out   = bcd_q;
  assign err_out   = err_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Randomized bench for seg7_scan_capture against a cycle-level behavioural
// model of strobe periods, frame assembly and the output slot.
module tb_seg7_scan_capture;
  localparam int DIGITS = 4;
  localparam int SETTLE = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [6:0]          seg_in = '0;
  logic [DIGITS-1:0]   dig_sel = '0;
  logic                out_ready = 1'b0;
  logic [4*DIGITS-1:0] bcd_out;
  logic [DIGITS-1:0]   err_out;
  logic                out_valid, overrun, frame_err;

  always #5 clk = ~clk;

  seg7_scan_capture #(.DIGITS(DIGITS), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_sel(dig_sel),
    .bcd_out(bcd_out), .err_out(err_out), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun), .frame_err(frame_err)
  );

  int n_vec = 0;
  int n_bad = 0;
  bit rnd_rdy = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] pats [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                            7'h5B, 7'h1F, 7'h70, 7'h7F, 7'h73};
  int                  m_run, m_mh, m_next;
  logic [DIGITS-1:0]   m_psel;
  logic [6:0]          m_pseg;
  bit                  m_in;
  logic [3:0]          m_bcd [DIGITS];
  logic                m_err [DIGITS];
  logic                m_valid, m_ovr, m_ferr;
  logic [4*DIGITS-1:0] m_word;
  logic [DIGITS-1:0]   m_eword;

  function automatic void decode(input logic [6:0] s, output logic [3:0] b, output logic e);
    b = 4'hF;
    e = (s != 7'h00);
    for (int i = 0; i < 10; i++)
      if (pats[i] == s) begin
        b = 4'(i);
        e = 1'b0;
      end
  endfunction

  task automatic model_reset();
    m_run = 0; m_mh = 0; m_next = 0; m_in = 0;
    m_psel = '0; m_pseg = '0;
    for (int i = 0; i < DIGITS; i++) begin
      m_bcd[i] = 4'h0;
      m_err[i] = 1'b0;
    end
    m_valid = 0; m_ovr = 0; m_ferr = 0; m_word = '0; m_eword = '0;
  endtask

  task automatic model_step();
    logic [DIGITS-1:0] s;
    logic [6:0] g;
    logic [3:0] b;
    logic e;
    int ones, k;
    bit samp, mfire, comp, abrt, strt, stor;
    s = dig_sel; g = seg_in;
    ones = $countones(s);
    comp = 0; abrt = 0; strt = 0; stor = 0; k = 0;
    if (ones == 1) m_run = (s == m_psel && g == m_pseg) ? m_run + 1 : 1;
    else m_run = 0;
    m_mh = (ones > 1) ? m_mh + 1 : 0;
    samp  = (ones == 1) && (m_run == SETTLE);
    mfire = (m_mh == SETTLE);
    for (int i = 0; i < DIGITS; i++) if (s[i]) k = i;
    decode(g, b, e);
    if (m_in && mfire) abrt = 1;
    else if (samp) begin
      if (!m_in) strt = (k == 0);
      else if (k == m_next) stor = 1;
      else begin
        abrt = 1;
        strt = (k == 0);
      end
    end
    if (abrt) m_in = 0;
    if (strt) begin
      for (int i = 0; i < DIGITS; i++) begin
        m_bcd[i] = 4'h0;
        m_err[i] = 1'b0;
      end
      m_bcd[0] = b; m_err[0] = e; m_next = 1; m_in = 1;
      if (DIGITS == 1) begin
        comp = 1;
        m_in = 0;
      end
    end
    if (stor) begin
      m_bcd[k] = b; m_err[k] = e;
      if (k == DIGITS - 1) begin
        comp = 1;
        m_in = 0;
      end else m_next++;
    end
    m_ferr = abrt;
    m_ovr  = 0;
    if (comp) begin
      if (!m_valid || out_ready) begin
        for (int i = 0; i < DIGITS; i++) begin
          m_word[4*i +: 4] = m_bcd[i];
          m_eword[i]       = m_err[i];
        end
        m_valid = 1;
      end else m_ovr = 1;
    end else if (m_valid && out_ready) m_valid = 0;
    m_psel = s; m_pseg = g;
  endtask

  // ---------------- stimulus ----------------
  task automatic cycle();
    if (rnd_rdy) out_ready = ($urandom_range(0, 9) < 6);
    @(posedge clk);
    model_step();
    #1;
    check("out_valid", out_valid, m_valid);
    check("overrun", overrun, m_ovr);
    check("frame_err", frame_err, m_ferr);
    if (m_valid) begin
      check("bcd_out", bcd_out, m_word);
      check("err_out", err_out, m_eword);
    end
  endtask

  task automatic hold(input logic [DIGITS-1:0] sel, input logic [6:0] seg, input int n);
    for (int i = 0; i < n; i++) begin
      dig_sel = sel;
      seg_in  = seg;
      cycle();
    end
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_bcd", bcd_out, 0);
    check("rst_err", err_out, 0);
    check("rst_ovr", overrun, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    dig_sel = '0; seg_in = '0;
    @(posedge clk);
    @(posedge clk);
    #4 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int r, dg, seq;
    logic [DIGITS-1:0] ms;
    logic [6:0] pat;
    model_reset();
    #2;
    check("rst_valid", out_valid, 1'b0);
    check("rst_bcd", bcd_out, 0);
    check("rst_err", err_out, 0);
    #10 rst_n = 1'b1;

    // clean frame, then a second frame against a stalled consumer
    hold(4'b0001, 7'h79, 3); hold(4'b0010, 7'h5B, 3);
    hold(4'b0100, 7'h7E, 3); hold(4'b1000, 7'h70, 3);
    check("clean_bcd", bcd_out, 16'h7053);
    check("clean_err", err_out, 0);
    hold(4'b0001, 7'h30, 1); hold(4'b0001, 7'h6D, 2);
    hold(4'b0010, 7'h01, 3); hold(4'b0100, 7'h00, 3); hold(4'b1000, 7'h73, 3);
    check("held_bcd", bcd_out, 16'h7053);
    // consumer ready on the completion cycle: new frame replaces the held one
    out_ready = 1'b1;
    hold(4'b0001, 7'h6D, 3); hold(4'b0010, 7'h01, 3);
    hold(4'b0100, 7'h00, 3); hold(4'b1000, 7'h73, 3);
    check("err_frame_bcd", bcd_out, 16'h9FF2);
    check("err_frame_err", err_out, 4'b0010);
    // out-of-order strobe, then a full frame
    hold(4'b0001, 7'h33, 3); hold(4'b0100, 7'h1F, 3);
    hold(4'b0001, 7'h33, 3); hold(4'b0010, 7'h1F, 3);
    hold(4'b0100, 7'h7F, 3); hold(4'b1000, 7'h30, 3);
    // reset mid-capture, then a lone last digit must not complete anything
    hold(4'b0001, 7'h7E, 3); hold(4'b0010, 7'h30, 3); hold(4'b0100, 7'h6D, 3);
    do_reset();
    hold(4'b1000, 7'h79, 3);
    check("post_rst_valid", out_valid, 1'b0);

    rnd_rdy = 1'b1;
    seq = 0;
    for (int p = 0; p < 1200; p++) begin
      if (p == 400 || p == 800) do_reset();
      r = $urandom_range(0, 99);
      if (r < 5) hold('0, 7'h00, $urandom_range(1, 2));
      else if (r < 9) begin
        do ms = 4'($urandom_range(3, 15)); while ($countones(ms) < 2);
        hold(ms, 7'($urandom), $urandom_range(1, 3));
      end else begin
        dg = (r < 85) ? seq : int'($urandom_range(0, DIGITS - 1));
        r = $urandom_range(0, 99);
        if (r < 85) pat = pats[$urandom_range(0, 9)];
        else if (r < 90) pat = 7'h00;
        else pat = 7'($urandom);
        if ($urandom_range(0, 99) < 15) hold(4'(1 << dg), 7'($urandom), 1);
        hold(4'(1 << dg), pat, $urandom_range(1, 4));
        seq = (dg + 1) % DIGITS;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
